// File: rtl/z80_io_pkg.sv
// Shared types and default timing for the Z80 I/O bus initiator.
package z80_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } io_state_e;

    localparam int DEF_SETUP_CYCLES    = 32'sd2;
    localparam int DEF_STROBE_CYCLES   = 32'sd6;
    localparam int DEF_HOLD_CYCLES     = 32'sd2;
    localparam int DEF_RECOVERY_CYCLES = 32'sd4;
    localparam int DEF_WAIT_TIMEOUT    = 32'sd255;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/z80_io_if.sv
// Request/response handshake plus Z80 I/O pin bundle between the initiator and its surroundings.
interface z80_io_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] A;
    logic [7:0] cd_out;
    logic       cd_oe;
    logic [7:0] cd_in;
    logic       rd_iorq_n;
    logic       wr_iorq_n;
    logic       wait_n;

    modport master (
        input  req_valid, req_wr, req_addr, req_data, cd_in, wait_n,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               A, cd_out, cd_oe, rd_iorq_n, wr_iorq_n
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_data, cd_in, wait_n,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               A, cd_out, cd_oe, rd_iorq_n, wr_iorq_n
    );

endinterface

// File: rtl/z80_io_sync.sv
// Two-flop synchroniser for asynchronous bus inputs sampled in the clk_w domain.
module z80_io_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_s,
    output logic [WIDTH-1:0] sync_r
);

    logic [WIDTH-1:0] meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= async_s;
            sync_r <= meta_r;
        end
    end

endmodule

// File: rtl/z80_io_master.sv
// Z80 I/O bus initiator: turns single-beat requests into IORQ read/write cycles with
// programmable setup/strobe/hold/recovery timing and WAIT-driven strobe extension.
module z80_io_master
    import z80_io_pkg::*;
#(
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES   = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
    parameter int WAIT_TIMEOUT    = DEF_WAIT_TIMEOUT
) (
    input  logic     clk,
    input  logic     reset_n,
    z80_io_if.master bus
);

    localparam int MAX_T = max2(max2(SETUP_CYCLES, STROBE_CYCLES), max2(HOLD_CYCLES, RECOVERY_CYCLES));
    localparam int CNT_W = $clog2(MAX_T + 32'sd1);
    localparam int EXT_W = (WAIT_TIMEOUT > 32'sd0) ? $clog2(WAIT_TIMEOUT + 32'sd1) : 32'sd1;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVERY_CYCLES - 32'sd1);
    localparam logic [EXT_W-1:0] EXT_ZERO     = {EXT_W{1'b0}};
    localparam logic [EXT_W-1:0] EXT_ONE      = EXT_W'(32'd1);
    localparam logic [EXT_W-1:0] EXT_MAX      = EXT_W'(WAIT_TIMEOUT);

    if ((SETUP_CYCLES < 32'sd1) || (STROBE_CYCLES < 32'sd3) || (HOLD_CYCLES < 32'sd1) ||
        (RECOVERY_CYCLES < 32'sd1) || (WAIT_TIMEOUT < 32'sd1)) begin : g_bad_timing
        $error("z80_io_master: timing parameters out of range");
    end

    io_state_e        state_r,     state_nxt_s;
    logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;
    logic [EXT_W-1:0] ext_r,       ext_nxt_s;
    logic             wr_r,        wr_nxt_s;
    logic             req_ready_r, req_ready_nxt_s;
    logic             rsp_valid_r, rsp_valid_nxt_s;
    logic [7:0]       rsp_data_r,  rsp_data_nxt_s;
    logic             rsp_err_r,   rsp_err_nxt_s;
    logic [7:0]       a_r,         a_nxt_s;
    logic [7:0]       cd_out_r,    cd_out_nxt_s;
    logic             cd_oe_r,     cd_oe_nxt_s;
    logic             rd_n_r,      rd_n_nxt_s;
    logic             wr_n_r,      wr_n_nxt_s;
    logic [7:0]       cd_sync_r;
    logic             wait_sync_r;

    z80_io_sync #(.WIDTH(8), .RST_VAL(8'h00)) u_cd_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_s (bus.cd_in),
        .sync_r  (cd_sync_r)
    );

    z80_io_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_wait_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_s (bus.wait_n),
        .sync_r  (wait_sync_r)
    );

    // Next-state and next-output decode; outputs are registered so they line up with the state.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        ext_nxt_s       = ext_r;
        wr_nxt_s        = wr_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        a_nxt_s         = a_r;
        cd_out_nxt_s    = cd_out_r;
        cd_oe_nxt_s     = cd_oe_r;
        rd_n_nxt_s      = 1'b1;
        wr_n_nxt_s      = 1'b1;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_nxt_s     = bus.req_wr;
                    a_nxt_s      = bus.req_addr;
                    cd_out_nxt_s = bus.req_data;
                    cd_oe_nxt_s  = bus.req_wr;
                    cnt_nxt_s    = CNT_ZERO;
                    ext_nxt_s    = EXT_ZERO;
                    state_nxt_s  = ST_SETUP;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_STROBE;
                    rd_n_nxt_s  = wr_r;
                    wr_n_nxt_s  = ~wr_r;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_r != STROBE_LAST) begin
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                    rd_n_nxt_s = wr_r;
                    wr_n_nxt_s = ~wr_r;
                end else if (wait_sync_r) begin
                    state_nxt_s     = ST_HOLD;
                    cnt_nxt_s       = CNT_ZERO;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b0;
                    if (!wr_r) begin
                        rsp_data_nxt_s = cd_sync_r;
                    end else begin
                        rsp_data_nxt_s = rsp_data_r;
                    end
                end else if (ext_r == EXT_MAX) begin
                    // Responder never released WAIT: end the strobe and flag the error.
                    state_nxt_s     = ST_HOLD;
                    cnt_nxt_s       = CNT_ZERO;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b1;
                end else begin
                    ext_nxt_s  = ext_r + EXT_ONE;
                    rd_n_nxt_s = wr_r;
                    wr_n_nxt_s = ~wr_r;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    cd_oe_nxt_s = 1'b0;
                    state_nxt_s = ST_RECOVER;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_RECOVER: begin
                if (cnt_r == RECOVER_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                cd_oe_nxt_s = 1'b0;
            end
        endcase

        req_ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // State, counters and registered bus/response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            ext_r       <= EXT_ZERO;
            wr_r        <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_err_r   <= 1'b0;
            a_r         <= 8'h00;
            cd_out_r    <= 8'h00;
            cd_oe_r     <= 1'b0;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ext_r       <= ext_nxt_s;
            wr_r        <= wr_nxt_s;
            req_ready_r <= req_ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            a_r         <= a_nxt_s;
            cd_out_r    <= cd_out_nxt_s;
            cd_oe_r     <= cd_oe_nxt_s;
            rd_n_r      <= rd_n_nxt_s;
            wr_n_r      <= wr_n_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.A         = a_r;
    assign bus.cd_out    = cd_out_r;
    assign bus.cd_oe     = cd_oe_r;
    assign bus.rd_iorq_n = rd_n_r;
    assign bus.wr_iorq_n = wr_n_r;

endmodule

// File: tb/tb_z80_io_master.sv
// Directed bench for z80_io_master: strobe widths, latencies, WAIT extension/abort, back-to-back and reset.
module tb_z80_io_master;

    logic clk = 1'b0;
    logic reset_n;

    z80_io_if bus_if();

    z80_io_master dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Negedge bus monitor: running totals the directed steps difference against.
    int   cyc_n = 0, rd_low_cnt = 0, wr_low_cnt = 0, oe_high_cnt = 0;
    int   rsp_cnt = 0, rsp_n = 0, acc_cnt = 0, acc_n = 0, acc_prev_n = 0, rdy_n = 0;
    int   both_low_cnt = 0, oe_glitch_cnt = 0;
    logic [7:0] rsp_d = 8'h00;
    logic       rsp_e = 1'b0;
    logic       prev_oe = 1'b0, prev_ready = 1'b0;

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (bus_if.rd_iorq_n === 1'b0) rd_low_cnt <= rd_low_cnt + 1;
        if (bus_if.wr_iorq_n === 1'b0) wr_low_cnt <= wr_low_cnt + 1;
        if (bus_if.cd_oe === 1'b1) oe_high_cnt <= oe_high_cnt + 1;
        if (bus_if.req_valid && bus_if.req_ready) begin
            acc_cnt    <= acc_cnt + 1;
            acc_prev_n <= acc_n;
            acc_n      <= cyc_n + 1;
        end
        if (bus_if.rsp_valid === 1'b1) begin
            rsp_cnt <= rsp_cnt + 1;
            rsp_n   <= cyc_n + 1;
            rsp_d   <= bus_if.rsp_data;
            rsp_e   <= bus_if.rsp_err;
        end
        if (bus_if.req_ready && !prev_ready) rdy_n <= cyc_n + 1;
        if (!bus_if.rd_iorq_n && !bus_if.wr_iorq_n) both_low_cnt <= both_low_cnt + 1;
        if ((bus_if.cd_oe !== prev_oe) && (!bus_if.rd_iorq_n || !bus_if.wr_iorq_n))
            oe_glitch_cnt <= oe_glitch_cnt + 1;
        prev_oe    <= bus_if.cd_oe;
        prev_ready <= bus_if.req_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b1;
        bus_if.req_wr    = wr;
        bus_if.req_addr  = addr;
        bus_if.req_data  = data;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int rsp_target);
        int n;
        n = 0;
        while (!((rsp_cnt >= rsp_target) && (bus_if.req_ready === 1'b1)) && (n < 600)) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", (n < 600) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int s_rd, s_wr, s_oe, s_rsp, s_acc;

    initial begin
        reset_n          = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_wr    = 1'b0;
        bus_if.req_addr  = 8'h00;
        bus_if.req_data  = 8'h00;
        bus_if.cd_in     = 8'h00;
        bus_if.wait_n    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {24'd0, bus_if.rsp_data},  32'd0);
        chk("rst_rsp_err",   {31'd0, bus_if.rsp_err},   32'd0);
        chk("rst_A",         {24'd0, bus_if.A},         32'd0);
        chk("rst_cd_out",    {24'd0, bus_if.cd_out},    32'd0);
        chk("rst_cd_oe",     {31'd0, bus_if.cd_oe},     32'd0);
        chk("rst_rd_n",      {31'd0, bus_if.rd_iorq_n}, 32'd1);
        chk("rst_wr_n",      {31'd0, bus_if.wr_iorq_n}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // 1: write 0x8F to port 0x99, no WAIT.
        s_rd = rd_low_cnt; s_wr = wr_low_cnt; s_rsp = rsp_cnt;
        issue(1'b1, 8'h99, 8'h8F);
        repeat (8) @(posedge clk);
        #1;
        chk("t1_rsp_valid_hold", {31'd0, bus_if.rsp_valid}, 32'd1);
        chk("t1_A",              {24'd0, bus_if.A},         32'h99);
        chk("t1_cd_out",         {24'd0, bus_if.cd_out},    32'h8F);
        chk("t1_cd_oe_hold",     {31'd0, bus_if.cd_oe},     32'd1);
        wait_idle(s_rsp + 1);
        chk("t1_wr_low",     wr_low_cnt - s_wr, 32'd6);
        chk("t1_rd_low",     rd_low_cnt - s_rd, 32'd0);
        chk("t1_rsp_lat",    rsp_n - acc_n,     32'd9);
        chk("t1_ready_lat",  rdy_n - acc_n,     32'd15);
        chk("t1_rsp_err",    {31'd0, rsp_e},    32'd0);
        chk("t1_A_retained", {24'd0, bus_if.A}, 32'h99);
        chk("t1_cd_oe_off",  {31'd0, bus_if.cd_oe}, 32'd0);

        // 2: read port 0x98, responder drives 0x5A.
        bus_if.cd_in = 8'h5A;
        s_rd = rd_low_cnt; s_wr = wr_low_cnt; s_oe = oe_high_cnt; s_rsp = rsp_cnt;
        issue(1'b0, 8'h98, 8'h00);
        wait_idle(s_rsp + 1);
        chk("t2_rd_low",   rd_low_cnt - s_rd,  32'd6);
        chk("t2_wr_low",   wr_low_cnt - s_wr,  32'd0);
        chk("t2_oe_high",  oe_high_cnt - s_oe, 32'd0);
        chk("t2_rsp_data", {24'd0, rsp_d},     32'h5A);
        chk("t2_rsp_err",  {31'd0, rsp_e},     32'd0);
        chk("t2_rsp_lat",  rsp_n - acc_n,      32'd9);
        chk("t2_rsp_count", rsp_cnt - s_rsp,   32'd1);

        // 3: read with WAIT held so that 10 extension cycles are inserted.
        bus_if.cd_in  = 8'h3C;
        bus_if.wait_n = 1'b0;
        s_rd = rd_low_cnt; s_rsp = rsp_cnt;
        issue(1'b0, 8'h42, 8'h00);
        repeat (15) @(posedge clk);
        #1;
        bus_if.wait_n = 1'b1;
        wait_idle(s_rsp + 1);
        chk("t3_rd_low",   rd_low_cnt - s_rd, 32'd16);
        chk("t3_rsp_lat",  rsp_n - acc_n,     32'd19);
        chk("t3_rsp_data", {24'd0, rsp_d},    32'h3C);
        chk("t3_rsp_err",  {31'd0, rsp_e},    32'd0);

        // 4: WAIT stuck low -> abort after 255 extension cycles.
        bus_if.cd_in  = 8'hEE;
        bus_if.wait_n = 1'b0;
        s_rd = rd_low_cnt; s_rsp = rsp_cnt;
        issue(1'b0, 8'h11, 8'h00);
        wait_idle(s_rsp + 1);
        chk("t4_rd_low",     rd_low_cnt - s_rd, 32'd261);
        chk("t4_rsp_lat",    rsp_n - acc_n,     32'd264);
        chk("t4_rsp_err",    {31'd0, rsp_e},    32'd1);
        chk("t4_rsp_data",   {24'd0, rsp_d},    32'h3C);
        chk("t4_ready_lat",  rdy_n - acc_n,     32'd270);
        chk("t4_rd_n_idle",  {31'd0, bus_if.rd_iorq_n}, 32'd1);
        bus_if.wait_n = 1'b1;
        repeat (4) @(posedge clk);

        // 5: back-to-back writes with req_valid held high.
        s_wr = wr_low_cnt; s_rsp = rsp_cnt; s_acc = acc_cnt;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b1;
        bus_if.req_wr    = 1'b1;
        bus_if.req_addr  = 8'h10;
        bus_if.req_data  = 8'hA5;
        @(posedge clk);
        #1;
        bus_if.req_addr  = 8'h20;
        bus_if.req_data  = 8'h5B;
        for (int n = 0; (n < 100) && (acc_cnt < s_acc + 2); n++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        wait_idle(s_rsp + 2);
        chk("t5_accepts",   acc_cnt - s_acc,    32'd2);
        chk("t5_acc_gap",   acc_n - acc_prev_n, 32'd15);
        chk("t5_rsp_count", rsp_cnt - s_rsp,    32'd2);
        chk("t5_wr_low",    wr_low_cnt - s_wr,  32'd12);
        chk("t5_A",         {24'd0, bus_if.A},      32'h20);
        chk("t5_cd_out",    {24'd0, bus_if.cd_out}, 32'h5B);

        // 6: reset asserted in the middle of a write strobe.
        s_rsp = rsp_cnt;
        issue(1'b1, 8'h77, 8'hC3);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_wr_low_pre", {31'd0, bus_if.wr_iorq_n}, 32'd0);
        chk("t6_cd_oe_pre",  {31'd0, bus_if.cd_oe},     32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_wr_n_rst",     {31'd0, bus_if.wr_iorq_n}, 32'd1);
        chk("t6_cd_oe_rst",    {31'd0, bus_if.cd_oe},     32'd0);
        chk("t6_A_rst",        {24'd0, bus_if.A},         32'd0);
        chk("t6_req_ready_rst", {31'd0, bus_if.req_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_req_ready_after", {31'd0, bus_if.req_ready}, 32'd1);
        chk("t6_no_rsp",          rsp_cnt - s_rsp,           32'd0);
        chk("t6_wr_n_after",      {31'd0, bus_if.wr_iorq_n}, 32'd1);

        chk("never_both_strobes", both_low_cnt,  32'd0);
        chk("oe_stable_in_strobe", oe_glitch_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
